car_motion_controller: RTL and testbench

//  Per-frame car position/state engine upstream of the car sprite renderer.

---
 rtl/car_motion_controller.sv | 168 ++++++++++++++++
 tb/tb_car_motion_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/car_motion_controller.sv
`default_nettype none
// ============================================================================
// Module      : car_motion_controller
// Description : Per-frame position and state engine for the player car.
//               All updates happen on frame_tick cycles; outputs are
//               registered and hold between ticks.
// Ports       : pclk, reset (sync, active-high), frame_tick (1-cycle pulse),
//               btn_left/btn_right/btn_accel (levels)
//               -> car_position_x[7:0], car_position_y[9:0], speed[2:0],
//                  crashed, visible
// Revision    : 1.0 - initial release
// ============================================================================
module car_motion_controller #(
  parameter logic [7:0] ROAD_LEFT      = 8'd32,
  parameter logic [7:0] ROAD_RIGHT     = 8'd208,
  parameter logic [7:0] START_X        = 8'd120,
  parameter logic [9:0] START_Y        = 10'd400,
  parameter logic [7:0] STEP           = 8'd2,
  parameter logic [2:0] SPEED_MAX      = 3'd7,
  parameter logic [5:0] CRASH_FRAMES   = 6'd60,
  parameter logic [5:0] RESPAWN_FRAMES = 6'd48
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_accel,
  output logic [7:0] car_position_x,
  output logic [9:0] car_position_y,
  output logic [2:0] speed,
  output logic       crashed,
  output logic       visible
);

  typedef enum logic [1:0] {
    ST_DRIVE   = 2'd0,
    ST_CRASH   = 2'd1,
    ST_RESPAWN = 2'd2
  } state_t;

  state_t       state_q,   state_d;
  logic [7:0]   x_q,       x_d;
  logic [2:0]   speed_q,   speed_d;
  logic         crashed_q, crashed_d;
  logic         visible_q, visible_d;
  logic [5:0]   cnt_q,     cnt_d;

  // One sign bit of headroom so a step past either edge of the 8-bit range
  // is seen as out of bounds instead of wrapping.
  logic signed [8:0] x_step;
  logic              below_left;
  logic              above_right;
  logic [2:0]        speed_step;

  always_comb begin
    x_step = $signed({1'b0, x_q});
    if (btn_left && !btn_right) begin
      x_step = $signed({1'b0, x_q}) - $signed({1'b0, STEP});
    end else if (btn_right && !btn_left) begin
      x_step = $signed({1'b0, x_q}) + $signed({1'b0, STEP});
    end
    below_left  = (x_step < $signed({1'b0, ROAD_LEFT}));
    above_right = (x_step > $signed({1'b0, ROAD_RIGHT}));

    if (btn_accel) begin
      speed_step = (speed_q == SPEED_MAX) ? speed_q : speed_q + 3'd1;
    end else begin
      speed_step = (speed_q == 3'd0) ? speed_q : speed_q - 3'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    speed_d   = speed_q;
    crashed_d = crashed_q;
    visible_d = visible_q;
    cnt_d     = cnt_q;

    if (frame_tick) begin
      case (state_q)
        ST_DRIVE: begin
          visible_d = 1'b1;
          if (below_left || above_right) begin
            x_d       = below_left ? ROAD_LEFT : ROAD_RIGHT;
            speed_d   = 3'd0;
            crashed_d = 1'b1;
            cnt_d     = CRASH_FRAMES - 6'd1;
            state_d   = ST_CRASH;
          end else begin
            x_d     = x_step[7:0];
            speed_d = speed_step;
          end
        end

        ST_CRASH: begin
          speed_d   = 3'd0;
          visible_d = 1'b1;
          if (cnt_q == 6'd0) begin
            state_d   = ST_RESPAWN;
            x_d       = START_X;
            crashed_d = 1'b0;
            cnt_d     = RESPAWN_FRAMES - 6'd1;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
          // Blink phase on entry follows the freshly loaded counter.
          if (cnt_q == 6'd0) begin
            visible_d = ~cnt_d[2];
          end
        end

        ST_RESPAWN: begin
          // Invulnerable: out-of-bounds clamps but never crashes.
          if (below_left) begin
            x_d = ROAD_LEFT;
          end else if (above_right) begin
            x_d = ROAD_RIGHT;
          end else begin
            x_d = x_step[7:0];
          end
          speed_d = speed_step;
          if (cnt_q == 6'd0) begin
            state_d   = ST_DRIVE;
            visible_d = 1'b1;
          end else begin
            cnt_d     = cnt_q - 6'd1;
            visible_d = ~cnt_d[2];
          end
        end

        default: begin
          state_d   = ST_DRIVE;
          crashed_d = 1'b0;
          visible_d = 1'b1;
          cnt_d     = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q   <= ST_DRIVE;
      x_q       <= START_X;
      speed_q   <= 3'd0;
      crashed_q <= 1'b0;
      visible_q <= 1'b1;
      cnt_q     <= 6'd0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      speed_q   <= speed_d;
      crashed_q <= crashed_d;
      visible_q <= visible_d;
      cnt_q     <= cnt_d;
    end
  end

  assign car_position_x = x_q;
  assign car_position_y = START_Y;
  assign speed          = speed_q;
  assign crashed        = crashed_q;
  assign visible        = visible_q;

endmodule
`default_nettype wire

// File: tb/tb_car_motion_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_car_motion_controller
// Description : Directed self-checking bench for car_motion_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_car_motion_controller;

  logic       pclk;
  logic       reset;
  logic       frame_tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_accel;
  logic [7:0] car_position_x;
  logic [9:0] car_position_y;
  logic [2:0] speed;
  logic       crashed;
  logic       visible;

  int checks   = 0;
  int failures = 0;

  car_motion_controller u_dut (
    .pclk           (pclk),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .btn_accel      (btn_accel),
    .car_position_x (car_position_x),
    .car_position_y (car_position_y),
    .speed          (speed),
    .crashed        (crashed),
    .visible        (visible)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Single-cycle tick; returns at the falling edge after the tick was sampled.
  task automatic do_tick();
    @(negedge pclk);
    frame_tick = 1'b1;
    @(negedge pclk);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge pclk);
    reset = 1'b1;
    @(negedge pclk);
    reset = 1'b0;
  endtask

  int exp_x;
  int exp_vis;

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    btn_accel  = 1'b0;
    repeat (3) @(negedge pclk);
    reset = 1'b0;

    // Reset values
    check_eq("rst_x",       car_position_x, 120);
    check_eq("rst_y",       car_position_y, 400);
    check_eq("rst_speed",   speed,          0);
    check_eq("rst_crashed", crashed,        0);
    check_eq("rst_visible", visible,        1);

    // No tick -> no movement even with a button held
    btn_right = 1'b1;
    repeat (5) @(negedge pclk);
    check_eq("hold_no_tick_x", car_position_x, 120);

    // Test 1: 10 ticks steering right
    repeat (10) do_tick();
    check_eq("t1_x",       car_position_x, 140);
    check_eq("t1_y",       car_position_y, 400);
    check_eq("t1_speed",   speed,          0);
    check_eq("t1_crashed", crashed,        0);
    check_eq("t1_visible", visible,        1);

    // Test 2: accelerate 10 ticks, saturating at 7, then coast 3 ticks
    btn_right = 1'b0;
    btn_accel = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      do_tick();
      check_eq("t2_accel", speed, (i > 7) ? 7 : i);
    end
    btn_accel = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      do_tick();
      check_eq("t2_coast", speed, 7 - i);
    end
    check_eq("t2_x_held", car_position_x, 140);

    // Test 3: steer left to 34, then hit the left edge
    btn_left = 1'b1;
    repeat (53) do_tick();
    check_eq("t3_x34",      car_position_x, 34);
    check_eq("t3_speed0",   speed,          0);
    do_tick();
    check_eq("t3_x32",      car_position_x, 32);
    check_eq("t3_nocrash",  crashed,        0);
    do_tick();
    check_eq("t3_clamp_x",  car_position_x, 32);
    check_eq("t3_crashed",  crashed,        1);
    check_eq("t3_speed",    speed,          0);

    // Test 4: buttons ignored during CRASH; 59 ticks still crashed
    btn_left  = 1'b0;
    btn_right = 1'b1;
    btn_accel = 1'b1;
    repeat (59) do_tick();
    check_eq("t4_still_crashed", crashed,        1);
    check_eq("t4_x_held",        car_position_x, 32);
    check_eq("t4_speed0",        speed,          0);
    check_eq("t4_visible",       visible,        1);
    btn_right = 1'b0;
    btn_accel = 1'b0;
    do_tick();
    check_eq("t4_respawn_x",   car_position_x, 120);
    check_eq("t4_respawn_crs", crashed,        0);
    check_eq("t4_blink_0",     visible,        0);

    // Test 4/5: blink every 4 frames while steering right into the clamp
    btn_right = 1'b1;
    for (int k = 1; k <= 47; k++) begin
      do_tick();
      exp_x   = (120 + 2 * k > 208) ? 208 : 120 + 2 * k;
      exp_vis = (k / 4) % 2;
      check_eq("t5_x",       car_position_x, exp_x);
      check_eq("t4_blink",   visible,        exp_vis);
      check_eq("t5_crashed", crashed,        0);
    end
    // Last RESPAWN frame: clamps and returns to DRIVE fully visible
    do_tick();
    check_eq("t5_last_x",   car_position_x, 208);
    check_eq("t5_last_crs", crashed,        0);
    check_eq("t4_end_vis",  visible,        1);
    // Now in DRIVE: stepping past the right edge crashes
    do_tick();
    check_eq("drv_right_x",   car_position_x, 208);
    check_eq("drv_right_crs", crashed,        1);

    // Test 6: reset while crashed with counter at 30
    btn_right = 1'b0;
    repeat (29) do_tick();
    check_eq("t6_pre_crs", crashed, 1);
    do_reset();
    check_eq("t6_x",       car_position_x, 120);
    check_eq("t6_crashed", crashed,        0);
    check_eq("t6_speed",   speed,          0);
    check_eq("t6_visible", visible,        1);
    btn_right = 1'b1;
    do_tick();
    check_eq("t6_drive_x",   car_position_x, 122);
    check_eq("t6_drive_crs", crashed,        0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
